multi_chan_clk_divider: RTL and testbench

- N-channel programmable integer clock divider. Each channel has its own ratio and enable, derived from one reference clock.
- Adds per-channel ratio shadowing with glitch-free updates at period boundaries, and graceful stop at the end of a period.
- Adds bypass (ratio 0/1), a rising-edge tick strobe, and a global phase-align sync across channels.
- Sits in the wake/handshake clocking path, feeding sideband and timer logic with several slow clocks.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 121 ++++++++++++
 rtl/multi_chan_clk_divider.sv | 38 +++
 tb/tb_multi_chan_clk_divider.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
// Channel state encoding, minimum dividing ratio and the high-phase length helper.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BYP  = 2'd2
    } chan_state_e;

    localparam int MIN_DIV = 2;

    // High-phase length of a period: ceil(R/2), giving a duty of ceil(R/2)/R.
    function automatic logic [31:0] ceil_half(input logic [31:0] ratio);
        return ratio - (ratio >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN/BYP FSM, period counter with shadowed ratio,
// registered divided clock and tick, and the bypass output mux.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_ratio,
    input  logic                 i_sync,
    output logic                 o_div_clk,
    output logic                 o_div_tick,
    output chan_state_e          o_state
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    chan_state_e          state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] act_ratio;
    logic [DIV_WIDTH-1:0] high_len;
    logic                 div_q;
    logic                 tick_q;
    logic                 wrap;
    logic                 ratio_ok;

    assign high_len = DIV_WIDTH'(ceil_half(32'(act_ratio)));
    // act_ratio >= 2 whenever RUN, so act_ratio - 1 never underflows where it matters.
    assign wrap     = (cnt == act_ratio - ONE);
    assign ratio_ok = (i_ratio >= DIV_WIDTH'(MIN_DIV));

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            act_ratio <= '0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    div_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (i_en) begin
                        if (ratio_ok) begin
                            state     <= RUN;
                            act_ratio <= i_ratio;
                        end else begin
                            state  <= BYP;
                            tick_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wrap && !i_en) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        div_q  <= 1'b0;
                        tick_q <= 1'b0;
                    end else if (i_sync) begin
                        // Re-phase: the next edge starts a fresh period with the new ratio.
                        cnt    <= '0;
                        div_q  <= 1'b0;
                        if (ratio_ok) begin
                            act_ratio <= i_ratio;
                            tick_q    <= 1'b0;
                        end else begin
                            state  <= BYP;
                            tick_q <= 1'b1;
                        end
                    end else begin
                        div_q  <= (cnt < high_len);
                        tick_q <= (cnt == '0);
                        if (wrap) begin
                            cnt <= '0;
                            if (!ratio_ok) begin
                                state  <= BYP;
                                tick_q <= 1'b1;
                            end else begin
                                act_ratio <= i_ratio;
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                BYP: begin
                    if (!i_en) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        div_q  <= 1'b0;
                        tick_q <= 1'b0;
                    end else if (ratio_ok) begin
                        // Enter mid-high so the output stays high across the switch.
                        state     <= RUN;
                        act_ratio <= i_ratio;
                        cnt       <= ONE;
                        div_q     <= 1'b1;
                        tick_q    <= 1'b1;
                    end else begin
                        tick_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    div_q  <= 1'b0;
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_div_clk  = (state == BYP) ? i_ref_clk : div_q;
    assign o_div_tick = tick_q;
    assign o_state    = state;

endmodule

// File: rtl/multi_chan_clk_divider.sv
// N-channel programmable integer clock divider built from independent channels
// that share one reference clock, reset and phase-align sync pulse.
module multi_chan_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                        i_ref_clk,
    input  logic                        i_rst,
    input  logic [NUM_CH-1:0]           i_clk_en,
    input  logic [NUM_CH*DIV_WIDTH-1:0] i_div_ratio,
    input  logic                        i_sync,
    output logic [NUM_CH-1:0]           o_div_clk,
    output logic [NUM_CH-1:0]           o_div_tick,
    output logic [NUM_CH-1:0]           o_running
);

    chan_state_e ch_state [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        clk_div_chan #(
            .DIV_WIDTH(DIV_WIDTH)
        ) u_chan (
            .i_ref_clk (i_ref_clk),
            .i_rst     (i_rst),
            .i_en      (i_clk_en[k]),
            .i_ratio   (i_div_ratio[k*DIV_WIDTH +: DIV_WIDTH]),
            .i_sync    (i_sync),
            .o_div_clk (o_div_clk[k]),
            .o_div_tick(o_div_tick[k]),
            .o_state   (ch_state[k])
        );

        assign o_running[k] = (ch_state[k] != IDLE);
    end

endmodule

// File: tb/tb_multi_chan_clk_divider.sv
// Directed bench for multi_chan_clk_divider: per-cycle expected
// {running, tick, div_clk} entries are queued and compared after each edge.
module tb_multi_chan_clk_divider;

    localparam int NUM_CH    = 4;
    localparam int DIV_WIDTH = 16;
    localparam int W         = 5;

    logic                        i_ref_clk = 1'b0;
    logic                        i_rst;
    logic [NUM_CH-1:0]           i_clk_en;
    logic [NUM_CH*DIV_WIDTH-1:0] i_div_ratio;
    logic                        i_sync;
    logic [NUM_CH-1:0]           o_div_clk;
    logic [NUM_CH-1:0]           o_div_tick;
    logic [NUM_CH-1:0]           o_running;

    // Entry layout: {channel[1:0], running, tick, div_clk}
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    string        test_tag = "init";

    multi_chan_clk_divider #(
        .NUM_CH   (NUM_CH),
        .DIV_WIDTH(DIV_WIDTH)
    ) dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst      (i_rst),
        .i_clk_en   (i_clk_en),
        .i_div_ratio(i_div_ratio),
        .i_sync     (i_sync),
        .o_div_clk  (o_div_clk),
        .o_div_tick (o_div_tick),
        .o_running  (o_running)
    );

    // ---------------- clock / watchdog ----------------
    always #5 i_ref_clk = ~i_ref_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {running, tick, div_clk} for a RUN channel at period phase ph (-1 = armed, output not yet high).
    function automatic logic [2:0] exp_run(input int r, input int ph);
        int hi;
        hi = (r + 1) / 2;
        if (ph < 0) return 3'b100;
        return {1'b1, (ph == 0), (ph < hi)};
    endfunction

    task automatic push_exp(input int ch, input logic [2:0] val);
        logic [1:0] c;
        c = ch[1:0];
        exp_q.push_back({c, val});
    endtask

    // Advance one edge, then compare every queued expectation for this edge.
    task automatic step();
        logic [W-1:0] e;
        int ch;
        @(posedge i_ref_clk);
        #1;
        cyc++;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ch = int'(e[4:3]);
            check($sformatf("%s ch%0d cyc%0d", test_tag, ch, cyc),
                  {29'd0, o_running[ch], o_div_tick[ch], o_div_clk[ch]},
                  {29'd0, e[2:0]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_ratio(input int ch, input int val);
        i_div_ratio[ch*DIV_WIDTH +: DIV_WIDTH] = val[DIV_WIDTH-1:0];
    endtask

    task automatic apply_reset();
        i_rst       = 1'b1;
        i_clk_en    = '0;
        i_sync      = 1'b0;
        i_div_ratio = '0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NUM_CH; c++) push_exp(c, 3'b000);
            step();
        end
        i_rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ph, ph0, ph1;
        int rat [NUM_CH];
        i_rst       = 1'b1;
        i_clk_en    = '0;
        i_sync      = 1'b0;
        i_div_ratio = '0;

        // Reset state on all channels.
        test_tag = "reset";
        apply_reset();

        // Ratio 5: armed edge, then high 3 / low 2 with tick on each rise.
        test_tag = "div5";
        set_ratio(0, 5);
        i_clk_en[0] = 1'b1;
        ph = -1;
        for (int k = 0; k < 16; k++) begin
            push_exp(0, exp_run(5, ph));
            push_exp(1, 3'b000);
            step();
            ph = (ph + 1) % 5;
        end

        // Ratio 4 -> 7 written at cnt=1: current period stays 2/2, then 4/3.
        test_tag = "shadow";
        apply_reset();
        set_ratio(0, 4);
        i_clk_en[0] = 1'b1;
        push_exp(0, exp_run(4, -1)); step();
        push_exp(0, exp_run(4, 0));  step();
        set_ratio(0, 7);
        for (int p = 1; p < 4; p++) begin
            push_exp(0, exp_run(4, p));
            step();
        end
        for (int k = 0; k < 14; k++) begin
            push_exp(0, exp_run(7, k % 7));
            step();
        end

        // Enable dropped at cnt=1 of ratio 6: period completes, then IDLE low.
        test_tag = "graceful_stop";
        apply_reset();
        set_ratio(1, 6);
        i_clk_en[1] = 1'b1;
        push_exp(1, exp_run(6, -1)); step();
        push_exp(1, exp_run(6, 0));  step();
        i_clk_en[1] = 1'b0;
        for (int p = 1; p < 5; p++) begin
            push_exp(1, exp_run(6, p));
            step();
        end
        for (int k = 0; k < 6; k++) begin
            push_exp(1, 3'b000);
            step();
        end

        // Ratios 3 and 8 out of phase, then a sync pulse aligns them.
        test_tag = "sync";
        apply_reset();
        set_ratio(0, 3);
        i_clk_en[0] = 1'b1;
        ph0 = -1;
        for (int k = 0; k < 2; k++) begin
            push_exp(0, exp_run(3, ph0));
            push_exp(1, 3'b000);
            step();
            ph0 = (ph0 + 1) % 3;
        end
        set_ratio(1, 8);
        i_clk_en[1] = 1'b1;
        ph1 = -1;
        for (int k = 0; k < 6; k++) begin
            push_exp(0, exp_run(3, ph0));
            push_exp(1, exp_run(8, ph1));
            step();
            ph0 = (ph0 + 1) % 3;
            ph1 = (ph1 + 1) % 8;
        end
        i_sync = 1'b1;
        push_exp(0, exp_run(3, -1));
        push_exp(1, exp_run(8, -1));
        push_exp(2, 3'b000);
        step();
        i_sync = 1'b0;
        ph0 = 0;
        ph1 = 0;
        for (int k = 0; k < 18; k++) begin
            push_exp(0, exp_run(3, ph0));
            push_exp(1, exp_run(8, ph1));
            step();
            ph0 = (ph0 + 1) % 3;
            ph1 = (ph1 + 1) % 8;
        end

        // Bypass with ratio 1, then switch to ratio 4 without dropping the output.
        test_tag = "bypass";
        apply_reset();
        set_ratio(0, 1);
        i_clk_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 3'b111);
            step();
        end
        @(negedge i_ref_clk);
        #1;
        check("bypass follows ref low", {31'd0, o_div_clk[0]}, 32'd0);
        set_ratio(0, 4);
        push_exp(0, 3'b111);
        step();
        @(negedge i_ref_clk);
        #1;
        check("switch held high", {31'd0, o_div_clk[0]}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            push_exp(0, exp_run(4, k % 4));
            step();
        end

        // Ratio 2 toggles every cycle.
        test_tag = "div2";
        apply_reset();
        set_ratio(3, 2);
        i_clk_en[3] = 1'b1;
        ph = -1;
        for (int k = 0; k < 9; k++) begin
            push_exp(3, exp_run(2, ph));
            step();
            ph = (ph + 1) % 2;
        end

        // Reset in the middle of a high phase on all channels, then ratio 0 goes to bypass.
        test_tag = "reset_mid";
        apply_reset();
        rat = '{5, 6, 7, 9};
        for (int c = 0; c < NUM_CH; c++) set_ratio(c, rat[c]);
        i_clk_en = '1;
        for (int c = 0; c < NUM_CH; c++) push_exp(c, exp_run(rat[c], -1));
        step();
        for (int c = 0; c < NUM_CH; c++) push_exp(c, exp_run(rat[c], 0));
        step();
        i_rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) push_exp(c, 3'b000);
        step();
        i_rst    = 1'b0;
        i_clk_en = 4'b0001;
        set_ratio(0, 0);
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 3'b111);
            for (int c = 1; c < NUM_CH; c++) push_exp(c, 3'b000);
            step();
        end
        i_clk_en[0] = 1'b0;
        push_exp(0, 3'b000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
